// File: rtl/spi_tx_buf_if.sv
// Bus bundle between the register/DMA write path, the SPI transmit core and
// spi_tx_buf.
//   master : write path + core side (drives writes, frame controls, config)
//   slave  : spi_tx_buf (drives head data, fill status and error flags)
interface spi_tx_buf_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              clr;
  logic              clr_err;
  logic              wr_en;
  logic [31:0]       wr_data;
  logic [1:0]        df;
  logic [ADDR_W:0]   thr;
  logic              tx_start;
  logic              tx_num_max_en;
  logic [31:0]       spi_tx_data;
  logic              txe;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              thr_flag;
  logic              ovr;
  logic              udr;
  logic              tx_done;

  modport master (
    output clr, clr_err, wr_en, wr_data, df, thr, tx_start, tx_num_max_en,
    input  spi_tx_data, txe, full, level, thr_flag, ovr, udr, tx_done
  );

  modport slave (
    input  clr, clr_err, wr_en, wr_data, df, thr, tx_start, tx_num_max_en,
    output spi_tx_data, txe, full, level, thr_flag, ovr, udr, tx_done
  );
endinterface

// File: rtl/spi_tx_buf.sv
// Transmit data buffer feeding the SPI transmit core.
// DEPTH-entry FIFO of 32-bit words; the head word is presented right-justified
// and masked to the frame size, qualified by txe. One entry is popped per
// tx_start. Tracks level, low-watermark, overrun/underrun and end-of-transfer.
// Ports:
//   sclk_tx     : transmit clock, rising edge
//   spi_tx_rstn : asynchronous active-low reset
//   bus         : spi_tx_buf_if slave modport (write path, core controls,
//                 head data, status and error flags)
module spi_tx_buf #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic          sclk_tx,
  input  logic          spi_tx_rstn,
  spi_tx_buf_if.slave   bus
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W-1:0] level_nxt;
  logic             thr_flag_q, ovr_q, udr_q, tx_done_q;
  logic             thr_flag_nxt, ovr_nxt, udr_nxt, tx_done_nxt;
  logic             empty, full;
  logic             pop, wr_ok, ovr_evt, udr_evt;
  logic [31:0]      head;

  // Pointer-derived status; extra MSB distinguishes full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A pop frees the slot in the same cycle, so a write while full is legal then
  assign pop     = bus.tx_start & ~empty;
  assign wr_ok   = bus.wr_en & (~full | pop);
  assign ovr_evt = bus.wr_en & full & ~pop;
  // A same-cycle write into an empty FIFO cannot serve the frame starting now
  assign udr_evt = bus.tx_start & empty;

  // Next-state for pointers, level-derived flag, errors and done pulse
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    level_nxt    = '0;
    thr_flag_nxt = 1'b1;
    ovr_nxt      = ovr_q;
    udr_nxt      = udr_q;
    tx_done_nxt  = 1'b0;

    if (bus.clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (wr_ok) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end

    level_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    thr_flag_nxt = (level_nxt <= bus.thr);

    // New error events take priority over clr_err
    if (bus.clr_err) begin
      ovr_nxt = 1'b0;
      udr_nxt = 1'b0;
    end
    if (ovr_evt) ovr_nxt = 1'b1;
    if (udr_evt) udr_nxt = 1'b1;

    tx_done_nxt = pop & bus.tx_num_max_en;
  end

  // State registers
  always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
    if (!spi_tx_rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      thr_flag_q <= 1'b1;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      thr_flag_q <= thr_flag_nxt;
      ovr_q      <= ovr_nxt;
      udr_q      <= udr_nxt;
      tx_done_q  <= tx_done_nxt;
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge sclk_tx) begin
    if (wr_ok && !bus.clr) mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
  end

  // Head word, masked to frame size and forced to zero when empty
  assign head = mem[rd_ptr[ADDR_W-1:0]];

  always_comb begin
    bus.spi_tx_data = '0;
    if (!empty) begin
      case (bus.df)
        2'b00:   bus.spi_tx_data = {24'b0, head[7:0]};
        2'b01:   bus.spi_tx_data = {16'b0, head[15:0]};
        default: bus.spi_tx_data = head;
      endcase
    end
  end

  assign bus.txe      = ~empty;
  assign bus.full     = full;
  assign bus.level    = wr_ptr - rd_ptr;
  assign bus.thr_flag = thr_flag_q;
  assign bus.ovr      = ovr_q;
  assign bus.udr      = udr_q;
  assign bus.tx_done  = tx_done_q;

endmodule

// File: tb/tb_spi_tx_buf.sv
module tb_spi_tx_buf;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  spi_tx_buf_if #(.ADDR_W(ADDR_W)) bus ();

  spi_tx_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sclk_tx     (clk),
    .spi_tx_rstn (rstn),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr           = 1'b0;
    bus.clr_err       = 1'b0;
    bus.wr_en         = 1'b0;
    bus.wr_data       = '0;
    bus.tx_start      = 1'b0;
    bus.tx_num_max_en = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pop_one(input logic last);
    bus.tx_start      = 1'b1;
    bus.tx_num_max_en = last;
    step();
    bus.tx_start      = 1'b0;
    bus.tx_num_max_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.df  = 2'b00;
    bus.thr = '0;
    rstn = 1'b0;
    #12;
    n_checks++; if (bus.txe !== 1'b0) begin n_fail++; $display("FAIL reset_txe got=%b exp=0", bus.txe); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.thr_flag !== 1'b1) begin n_fail++; $display("FAIL reset_thr_flag got=%b exp=1", bus.thr_flag); end
    n_checks++; if ({bus.ovr, bus.udr, bus.tx_done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus.ovr, bus.udr, bus.tx_done}); end
    n_checks++; if (bus.spi_tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=00000000", bus.spi_tx_data); end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_df8_single();
    bus.df  = 2'b00;
    bus.thr = '0;
    write_word(32'h12345678);
    n_checks++; if (bus.txe !== 1'b1) begin n_fail++; $display("FAIL df8_txe got=%b exp=1", bus.txe); end
    n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL df8_level got=%0d exp=1", bus.level); end
    n_checks++; if (bus.spi_tx_data !== 32'h00000078) begin n_fail++; $display("FAIL df8_data got=%h exp=00000078", bus.spi_tx_data); end
    n_checks++; if (bus.thr_flag !== 1'b0) begin n_fail++; $display("FAIL df8_thr_flag_lvl1 got=%b exp=0", bus.thr_flag); end
    pop_one(1'b0);
    n_checks++; if (bus.txe !== 1'b0) begin n_fail++; $display("FAIL df8_pop_txe got=%b exp=0", bus.txe); end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL df8_pop_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.spi_tx_data !== 32'h0) begin n_fail++; $display("FAIL df8_pop_data got=%h exp=00000000", bus.spi_tx_data); end
    n_checks++; if (bus.thr_flag !== 1'b1) begin n_fail++; $display("FAIL df8_pop_thr_flag got=%b exp=1", bus.thr_flag); end
  endtask

  task automatic test_df16_done();
    bus.df = 2'b01;
    write_word(32'hAABBCCDD);
    write_word(32'h11223344);
    write_word(32'h55667788);
    n_checks++; if (bus.spi_tx_data !== 32'h0000CCDD) begin n_fail++; $display("FAIL df16_head0 got=%h exp=0000CCDD", bus.spi_tx_data); end
    n_checks++; if (bus.level !== 4'd3) begin n_fail++; $display("FAIL df16_level got=%0d exp=3", bus.level); end
    pop_one(1'b0);
    n_checks++; if (bus.spi_tx_data !== 32'h00003344) begin n_fail++; $display("FAIL df16_head1 got=%h exp=00003344", bus.spi_tx_data); end
    n_checks++; if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL df16_done_early got=%b exp=0", bus.tx_done); end
    pop_one(1'b0);
    n_checks++; if (bus.spi_tx_data !== 32'h00007788) begin n_fail++; $display("FAIL df16_head2 got=%h exp=00007788", bus.spi_tx_data); end
    pop_one(1'b1);
    n_checks++; if (bus.tx_done !== 1'b1) begin n_fail++; $display("FAIL df16_done got=%b exp=1", bus.tx_done); end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL df16_level_end got=%0d exp=0", bus.level); end
    step();
    n_checks++; if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL df16_done_width got=%b exp=0", bus.tx_done); end
  endtask

  task automatic test_full_ovr();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    bus.df = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      w = 32'h01010101 * 32'(k);
      exp_q.push_back(w);
      write_word(w);
    end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_flag got=%b exp=1", bus.full); end
    n_checks++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL full_level got=%0d exp=8", bus.level); end
    write_word(32'hDEADBEEF);
    n_checks++; if (bus.ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b exp=1", bus.ovr); end
    n_checks++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL ovr_level got=%0d exp=8", bus.level); end
    // Write and pop together while full
    n_checks++; if (bus.spi_tx_data !== 32'h01010101) begin n_fail++; $display("FAIL full_head got=%h exp=01010101", bus.spi_tx_data); end
    bus.wr_en    = 1'b1;
    bus.wr_data  = 32'hCAFEF00D;
    bus.tx_start = 1'b1;
    step();
    idle_inputs();
    void'(exp_q.pop_front());
    exp_q.push_back(32'hCAFEF00D);
    n_checks++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL wrpop_level got=%0d exp=8", bus.level); end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL wrpop_full got=%b exp=1", bus.full); end
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    n_checks++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got=%b exp=0", bus.ovr); end
    for (int i = 0; i < 8; i++) begin
      w = exp_q.pop_front();
      n_checks++; if (bus.spi_tx_data !== w) begin n_fail++; $display("FAIL drain_%0d got=%h exp=%h", i, bus.spi_tx_data, w); end
      pop_one(1'b0);
    end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL drain_level got=%0d exp=0", bus.level); end
  endtask

  task automatic test_underrun();
    pop_one(1'b1);
    n_checks++; if (bus.udr !== 1'b1) begin n_fail++; $display("FAIL udr_set got=%b exp=1", bus.udr); end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL udr_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL udr_done got=%b exp=0", bus.tx_done); end
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    n_checks++; if (bus.udr !== 1'b0) begin n_fail++; $display("FAIL udr_clr got=%b exp=0", bus.udr); end
    bus.clr_err  = 1'b1;
    bus.tx_start = 1'b1;
    step();
    idle_inputs();
    n_checks++; if (bus.udr !== 1'b1) begin n_fail++; $display("FAIL udr_clr_race got=%b exp=1", bus.udr); end
    // Write into empty FIFO alongside tx_start: accepted, yet underruns
    bus.clr_err = 1'b1;
    step();
    bus.clr_err  = 1'b0;
    bus.wr_en    = 1'b1;
    bus.wr_data  = 32'h0000005A;
    bus.tx_start = 1'b1;
    step();
    idle_inputs();
    n_checks++; if (bus.udr !== 1'b1) begin n_fail++; $display("FAIL udr_wr_same got=%b exp=1", bus.udr); end
    n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL udr_wr_level got=%0d exp=1", bus.level); end
    pop_one(1'b0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
  endtask

  task automatic test_threshold();
    bus.thr = 4'd2;
    for (int k = 0; k < 4; k++) write_word(32'(k));
    n_checks++; if (bus.thr_flag !== 1'b0) begin n_fail++; $display("FAIL thr_lvl4 got=%b exp=0", bus.thr_flag); end
    pop_one(1'b0);
    n_checks++; if (bus.thr_flag !== 1'b0 || bus.level !== 4'd3) begin n_fail++; $display("FAIL thr_lvl3 got=%b/%0d exp=0/3", bus.thr_flag, bus.level); end
    repeat (19) step();
    pop_one(1'b0);
    n_checks++; if (bus.thr_flag !== 1'b1 || bus.level !== 4'd2) begin n_fail++; $display("FAIL thr_lvl2 got=%b/%0d exp=1/2", bus.thr_flag, bus.level); end
    repeat (19) step();
    pop_one(1'b0);
    n_checks++; if (bus.thr_flag !== 1'b1 || bus.level !== 4'd1) begin n_fail++; $display("FAIL thr_lvl1 got=%b/%0d exp=1/1", bus.thr_flag, bus.level); end
    repeat (19) step();
    pop_one(1'b0);
    n_checks++; if (bus.thr_flag !== 1'b1 || bus.level !== 4'd0) begin n_fail++; $display("FAIL thr_lvl0 got=%b/%0d exp=1/0", bus.thr_flag, bus.level); end
    bus.thr = '0;
  endtask

  task automatic test_clr_and_reset();
    pop_one(1'b0);
    for (int k = 0; k < 5; k++) write_word(32'hA0 + 32'(k));
    n_checks++; if (bus.level !== 4'd5) begin n_fail++; $display("FAIL clr_pre_level got=%0d exp=5", bus.level); end
    bus.clr      = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_data  = 32'hFFFFFFFF;
    bus.tx_start = 1'b1;
    step();
    idle_inputs();
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL clr_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.txe !== 1'b0) begin n_fail++; $display("FAIL clr_txe got=%b exp=0", bus.txe); end
    n_checks++; if ({bus.ovr, bus.udr} !== 2'b01) begin n_fail++; $display("FAIL clr_errs got=%b exp=01", {bus.ovr, bus.udr}); end
    // Asynchronous reset in the middle of a fill
    write_word(32'h11111111);
    write_word(32'h22222222);
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'h33333333;
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.txe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_txe got=%b exp=0", bus.txe); end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL rst_mid_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.spi_tx_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=00000000", bus.spi_tx_data); end
    n_checks++; if ({bus.udr, bus.thr_flag} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_flags got=%b exp=01", {bus.udr, bus.thr_flag}); end
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b1;
    test_reset();
    test_df8_single();
    test_df16_done();
    test_full_ovr();
    test_underrun();
    test_threshold();
    test_clr_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
